acc_ctrl_fsm: RTL and testbench

ACC_CTRL_FSM -- requirements
Module: acc_ctrl_fsm

---
 rtl/acc_ctrl_fsm.sv | 210 +++++++++++++++++++++
 tb/tb_acc_ctrl_fsm.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/acc_ctrl_fsm.sv
// Accumulator-machine control FSM: sequences fetch/decode/execute for a
// small accumulator datapath, with registered datapath strobes, a sticky
// halt flag, an illegal-opcode pulse and a retired-instruction counter.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a run pulse, all strobes low
// FETCH  | load IR and increment PC
// DECODE | opcode/operand latched, register file addressed by operand
// EXEC   | one-cycle execution of the latched opcode
// HALT   | sticky stop after opcode 1111, left only through reset
module acc_ctrl_fsm #(
    parameter int          REG_AW  = 4,
    parameter int          CNT_W   = 16,
    parameter logic [3:0]  ALU_ADD = 4'd0,
    parameter logic [3:0]  ALU_SUB = 4'd1,
    parameter logic [3:0]  ALU_NOR = 4'd8,
    parameter logic [3:0]  ALU_SHR = 4'd12,
    parameter logic [3:0]  ALU_SHL = 4'd13
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [REG_AW+3:0]   instr,
    input  logic                zero,
    input  logic                carry,
    output logic                LoadIR,
    output logic                IncPC,
    output logic                SelPC,
    output logic                LoadPC,
    output logic                LoadReg,
    output logic                DumpReg,
    output logic                LoadAcc,
    output logic [1:0]          SelAcc,
    output logic [3:0]          SelALU,
    output logic [REG_AW-1:0]   RegNumber,
    output logic                halted,
    output logic                illegal,
    output logic [CNT_W-1:0]    retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_NOR = 4'b0011;
    localparam logic [3:0] OP_LDR = 4'b0100;
    localparam logic [3:0] OP_STR = 4'b0101;
    localparam logic [3:0] OP_JZR = 4'b0110;
    localparam logic [3:0] OP_JZI = 4'b0111;
    localparam logic [3:0] OP_JCR = 4'b1000;
    localparam logic [3:0] OP_IL1 = 4'b1001;
    localparam logic [3:0] OP_JCI = 4'b1010;
    localparam logic [3:0] OP_SHL = 4'b1011;
    localparam logic [3:0] OP_SHR = 4'b1100;
    localparam logic [3:0] OP_LDI = 4'b1101;
    localparam logic [3:0] OP_IL2 = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t             state, state_nx;
    logic [3:0]         opcode_q;
    logic [REG_AW-1:0]  operand_q;

    logic               n_load_ir, n_inc_pc, n_sel_pc, n_load_pc;
    logic               n_load_reg, n_dump_reg, n_load_acc;
    logic [1:0]         n_sel_acc;
    logic [3:0]         n_sel_alu;
    logic [REG_AW-1:0]  n_reg_number;
    logic               n_halted, n_illegal;
    logic [CNT_W-1:0]   n_retired;

    // Next state plus the output values belonging to that next state, so
    // every output is registered on the edge that enters its state.  The
    // EXEC outputs are formed from zero/carry as seen on the DECODE->EXEC
    // edge, which is what makes flags outside DECODE irrelevant.
    always_comb begin
        state_nx     = state;
        n_load_ir    = 1'b0;
        n_inc_pc     = 1'b0;
        n_sel_pc     = 1'b0;
        n_load_pc    = 1'b0;
        n_load_reg   = 1'b0;
        n_dump_reg   = 1'b0;
        n_load_acc   = 1'b0;
        n_sel_acc    = 2'b00;
        n_sel_alu    = 4'd0;
        n_reg_number = '0;
        n_halted     = 1'b0;
        n_illegal    = 1'b0;
        n_retired    = retired;

        case (state)
            S_IDLE:   state_nx = run ? S_FETCH : S_IDLE;
            S_FETCH:  state_nx = S_DECODE;
            S_DECODE: state_nx = (opcode_q == OP_HLT) ? S_HALT : S_EXEC;
            S_EXEC:   state_nx = S_FETCH;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_IDLE;
        endcase

        // HALT entry retires the halt instruction itself.
        if (state == S_EXEC || (state == S_DECODE && state_nx == S_HALT))
            n_retired = retired + CNT_W'(1);

        case (state_nx)
            S_FETCH: begin
                n_load_ir = 1'b1;
                n_inc_pc  = 1'b1;
            end
            S_DECODE: n_reg_number = instr[REG_AW-1:0];
            S_EXEC: begin
                case (opcode_q)
                    OP_ADD, OP_SUB, OP_NOR: begin
                        n_load_acc   = 1'b1;
                        n_sel_acc    = 2'b10;
                        n_dump_reg   = 1'b1;
                        n_reg_number = operand_q;
                        n_sel_alu    = (opcode_q == OP_ADD) ? ALU_ADD :
                                       (opcode_q == OP_SUB) ? ALU_SUB : ALU_NOR;
                    end
                    OP_SHR, OP_SHL: begin
                        n_load_acc = 1'b1;
                        n_sel_acc  = 2'b10;
                        n_sel_alu  = (opcode_q == OP_SHR) ? ALU_SHR : ALU_SHL;
                    end
                    OP_LDR: begin
                        n_dump_reg   = 1'b1;
                        n_load_acc   = 1'b1;
                        n_reg_number = operand_q;
                    end
                    OP_STR: begin
                        n_load_reg   = 1'b1;
                        n_reg_number = operand_q;
                    end
                    OP_LDI: begin
                        n_sel_acc  = 2'b01;
                        n_load_acc = 1'b1;
                    end
                    OP_JZR, OP_JCR: begin
                        if ((opcode_q == OP_JZR) ? zero : carry) begin
                            n_load_pc    = 1'b1;
                            n_dump_reg   = 1'b1;
                            n_reg_number = operand_q;
                        end
                    end
                    OP_JZI, OP_JCI: begin
                        if ((opcode_q == OP_JZI) ? zero : carry) begin
                            n_load_pc = 1'b1;
                            n_sel_pc  = 1'b1;
                        end
                    end
                    OP_IL1, OP_IL2: n_illegal = 1'b1;
                    default: ;
                endcase
            end
            S_HALT: n_halted = 1'b1;
            default: ;
        endcase
    end

    // State, latched instruction fields and registered outputs; reset wins
    // over every transition, so an interrupted instruction is never counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            opcode_q  <= 4'd0;
            operand_q <= '0;
            LoadIR    <= 1'b0;
            IncPC     <= 1'b0;
            SelPC     <= 1'b0;
            LoadPC    <= 1'b0;
            LoadReg   <= 1'b0;
            DumpReg   <= 1'b0;
            LoadAcc   <= 1'b0;
            SelAcc    <= 2'b00;
            SelALU    <= 4'd0;
            RegNumber <= '0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
            retired   <= '0;
        end else begin
            state <= state_nx;
            if (state == S_FETCH) begin
                opcode_q  <= instr[REG_AW+3:REG_AW];
                operand_q <= instr[REG_AW-1:0];
            end
            LoadIR    <= n_load_ir;
            IncPC     <= n_inc_pc;
            SelPC     <= n_sel_pc;
            LoadPC    <= n_load_pc;
            LoadReg   <= n_load_reg;
            DumpReg   <= n_dump_reg;
            LoadAcc   <= n_load_acc;
            SelAcc    <= n_sel_acc;
            SelALU    <= n_sel_alu;
            RegNumber <= n_reg_number;
            halted    <= n_halted;
            illegal   <= n_illegal;
            retired   <= n_retired;
        end
    end

endmodule

// File: tb/tb_acc_ctrl_fsm.sv
// Scoreboard bench for acc_ctrl_fsm (REG_AW=4, CNT_W=4 so counter wrap is
// reachable quickly).  The driver pushes the expected output bundle for
// each clock edge; a monitor pops and compares at the following negedge.
module tb_acc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset, run, zero, carry;
    logic [7:0] instr;
    logic       LoadIR, IncPC, SelPC, LoadPC, LoadReg, DumpReg, LoadAcc;
    logic [1:0] SelAcc;
    logic [3:0] SelALU, RegNumber, retired;
    logic       halted, illegal;

    acc_ctrl_fsm #(.REG_AW(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .run(run), .instr(instr),
        .zero(zero), .carry(carry),
        .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC),
        .LoadReg(LoadReg), .DumpReg(DumpReg), .LoadAcc(LoadAcc),
        .SelAcc(SelAcc), .SelALU(SelALU), .RegNumber(RegNumber),
        .halted(halted), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       load_ir, inc_pc, sel_pc, load_pc, load_reg, dump_reg, load_acc;
        logic [1:0] sel_acc;
        logic [3:0] sel_alu;
        logic [3:0] reg_number;
        logic       halted, illegal;
        logic [3:0] retired;
    } out_t;

    out_t expq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   ret_m = 0;     // model retired count
    int   mstate = 0;    // 0 idle, 1 just executed, 2 halted

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    function automatic logic [7:0] rbyte();
        return 8'($urandom);
    endfunction

    function automatic out_t blank();
        out_t o = '0;
        o.retired = 4'(ret_m % 16);
        return o;
    endfunction

    // Expected EXEC-cycle outputs from the instruction table.
    function automatic out_t exec_vec(input logic [3:0] opc, input logic [3:0] opd,
                                      input bit z, input bit c);
        out_t o = blank();
        case (opc)
            4'd1: begin o.load_acc = 1; o.sel_acc = 2; o.sel_alu = 4'd0;  o.dump_reg = 1; o.reg_number = opd; end
            4'd2: begin o.load_acc = 1; o.sel_acc = 2; o.sel_alu = 4'd1;  o.dump_reg = 1; o.reg_number = opd; end
            4'd3: begin o.load_acc = 1; o.sel_acc = 2; o.sel_alu = 4'd8;  o.dump_reg = 1; o.reg_number = opd; end
            4'd12: begin o.load_acc = 1; o.sel_acc = 2; o.sel_alu = 4'd12; end
            4'd11: begin o.load_acc = 1; o.sel_acc = 2; o.sel_alu = 4'd13; end
            4'd4: begin o.dump_reg = 1; o.load_acc = 1; o.reg_number = opd; end
            4'd5: begin o.load_reg = 1; o.reg_number = opd; end
            4'd13: begin o.sel_acc = 1; o.load_acc = 1; end
            4'd6: if (z) begin o.load_pc = 1; o.dump_reg = 1; o.reg_number = opd; end
            4'd7: if (z) begin o.load_pc = 1; o.sel_pc = 1; end
            4'd8: if (c) begin o.load_pc = 1; o.dump_reg = 1; o.reg_number = opd; end
            4'd10: if (c) begin o.load_pc = 1; o.sel_pc = 1; end
            4'd9, 4'd14: o.illegal = 1;
            default: ;
        endcase
        return o;
    endfunction

    task automatic step(input bit r, input bit rn, input logic [7:0] in,
                        input bit z, input bit c, input out_t e);
        #1;
        reset = r; run = rn; instr = in; zero = z; carry = c;
        @(posedge clk);
        expq.push_back(e);
    endtask

    task automatic do_reset(input bit rn);
        ret_m  = 0;
        mstate = 0;
        step(1'b1, rn, rbyte(), rb(), rb(), blank());
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rbyte(), rb(), rb(), blank());
    endtask

    task automatic halt_cycles(input int n);
        out_t e;
        for (int i = 0; i < n; i++) begin
            e = blank();
            e.halted = 1'b1;
            step(1'b0, rb(), rbyte(), rb(), rb(), e);
        end
    endtask

    // rst_at: 0 none, 1 reset while in FETCH, 2 reset while in DECODE,
    // 3 reset while in EXEC (the instruction is then not retired).
    task automatic do_instr(input logic [3:0] opc, input logic [3:0] opd,
                            input bit z, input bit c, input int rst_at);
        out_t e;
        bit   rn;
        rn = (mstate == 0) ? 1'b1 : rb();
        if (mstate == 1) ret_m++;
        e = blank();
        e.load_ir = 1'b1;
        e.inc_pc  = 1'b1;
        step(1'b0, rn, rbyte(), rb(), rb(), e);
        if (rst_at == 1) begin do_reset(rb()); return; end

        e = blank();
        e.reg_number = opd;
        step(1'b0, rb(), {opc, opd}, rb(), rb(), e);
        if (rst_at == 2) begin do_reset(1'b1); return; end

        if (opc == 4'hF) begin
            ret_m++;
            e = blank();
            e.halted = 1'b1;
            mstate = 2;
        end else begin
            e = exec_vec(opc, opd, z, c);
            mstate = 1;
        end
        step(1'b0, rb(), rbyte(), z, c, e);
        if (rst_at == 3 && mstate == 1) do_reset(1'b1);
    endtask

    // Monitor: compare the DUT against the oldest pending expectation.
    always @(negedge clk) begin
        out_t got, e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            got = '{LoadIR, IncPC, SelPC, LoadPC, LoadReg, DumpReg, LoadAcc,
                    SelAcc, SelALU, RegNumber, halted, illegal, retired};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL outputs t=%0t got=%h exp=%h (ir pc selpc ldpc ldreg dump ldacc selacc alu reg halt ill ret)",
                         $time, got, e);
            end
        end
    end

    initial begin
        int opc_r, rst_r;
        reset = 1'b1; run = 1'b0; instr = 8'h00; zero = 1'b0; carry = 1'b0;
        @(posedge clk);

        do_reset(1'b0);
        idle_cycles(3);

        @(negedge clk);
        if ({LoadIR, IncPC, SelPC, LoadPC, LoadReg, DumpReg, LoadAcc,
             SelAcc, SelALU, RegNumber, halted, illegal, retired} !== '0) begin
            miscompares++;
            $display("FAIL reset state t=%0t outputs not all zero in IDLE after reset", $time);
        end

        // ADD r3, then its retirement shows on the next FETCH
        do_instr(4'd1, 4'd3, rb(), rb(), 0);
        do_instr(4'd0, 4'd0, rb(), rb(), 0);

        // JZI taken / untaken, JCR taken
        do_instr(4'd7, 4'd2, 1'b1, rb(), 0);
        do_instr(4'd7, 4'd2, 1'b0, rb(), 0);
        do_instr(4'd8, 4'd5, rb(), 1'b1, 0);
        do_instr(4'd8, 4'd5, rb(), 1'b0, 0);
        do_instr(4'd6, 4'd9, 1'b1, 1'b0, 0);
        do_instr(4'd10, 4'd1, 1'b0, 1'b1, 0);

        // every non-halt opcode once, then the illegal one explicitly
        for (int op = 0; op < 15; op++)
            do_instr(4'(op), 4'(op + 3), rb(), rb(), 0);
        do_instr(4'd9, 4'd0, rb(), rb(), 0);

        // HALT holds through run pulses until reset
        do_instr(4'hF, 4'hA, rb(), rb(), 0);
        halt_cycles(20);
        do_reset(1'b1);
        idle_cycles(2);

        // retired wraps 15 -> 0
        for (int i = 0; i < 17; i++) do_instr(4'd0, 4'd0, rb(), rb(), 0);

        // reset mid-EXEC with run asserted, and in FETCH / DECODE
        do_instr(4'd1, 4'd7, rb(), rb(), 3);
        idle_cycles(1);
        do_instr(4'd5, 4'd4, rb(), rb(), 1);
        do_instr(4'd4, 4'd4, rb(), rb(), 2);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            if (mstate == 2) begin
                halt_cycles(int'($urandom_range(1, 3)));
                do_reset(rb());
                if (rb()) idle_cycles(1);
            end else begin
                opc_r = int'($urandom_range(0, 15));
                rst_r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
                do_instr(4'(opc_r), 4'($urandom), rb(), rb(), rst_r);
            end
        end

        @(negedge clk);
        @(negedge clk);
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL expired wait: %0d expectations never compared", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        if (miscompares == 0) $display("PASS");
        else                  $display("FAIL");
        $finish;
    end

endmodule
